ps2_rx_hub: RTL and testbench
=============================

# ps2_rx_hub

Parametrised multi-channel PS/2 receive hub. It replaces per-device keyboard/mouse receivers wired side by side with NUM_CH identical receive channels, all feeding one shared output stream. Each channel synchronises, filters and deframes its PS/2 line, then checks odd parity and the stop bit. Finished bytes, tagged with channel number and error flag, are merged round-robin into a shared first-word-fall-through FIFO. The hub sits between the board PS/2 pins and the host-side command/packet logic.

## Interface
Parameters:
- NUM_CH, 2: number of PS/2 channels (1..8).
- FIFO_DEPTH, 8: shared output FIFO entries; power of 2, at least 2.
- FILTER_LEN, 8: consecutive equal samples needed to accept a PS/2 clock level change.
- TIMEOUT_CYCLES, 50000: idle cycles allowed mid-frame before abort (1 ms at 50 MHz).

Ports (CHW = max(1, clog2(NUM_CH))):
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  NUM_CH  raw PS/2 clock lines, one bit per channel; receive only.
- ps2_data  in  NUM_CH  raw PS/2 data lines.
- out_valid  out  1  FIFO head holds a record.
- out_ready  in  1  consumer accepts the head record.
- out_data  out  8  received byte (0x00 for a timeout record).
- out_ch  out  CHW  source channel of the head record.
- out_error  out  1  head record failed parity, stop-bit or timeout.
- overflow  out  NUM_CH  sticky: a frame on that channel was dropped.
- ovf_clr  in  1  clears all overflow bits; takes priority over a new set in the same cycle.

## Operation
- Per-channel front end:
  - Both lines pass a 2-FF synchroniser.
  - The filtered clock changes level only after FILTER_LEN consecutive synchronised samples at the new level.
  - A falling edge of the filtered clock is a one-cycle strobe. Data is sampled from the synchronised data line on that strobe.
- Per-channel frame FSM, advancing only on the strobe:
  - IDLE: sampled 0 → DATA with bit count 0. Sampled 1 is ignored.
  - DATA: shift LSB first. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: err = (XOR of the 8 data bits and the parity bit ≠ 1) OR (stop bit ≠ 1). Emit record {err, ch, data} → IDLE.
- Timeout: in any non-IDLE state, if TIMEOUT_CYCLES clocks pass with no strobe, the FSM returns to IDLE and emits {1, ch, 0x00}.
- Holding register: each channel has one record slot.
  - Emit into an empty slot → slot full.
  - Emit into a full slot → new record discarded and overflow[ch] set.
- Arbiter: round-robin among full slots.
  - Search starts at last-granted + 1 and wraps at NUM_CH-1 → 0.
  - At most one grant per cycle. The granted slot empties and its record is written to the FIFO.
  - No grant while FIFO count == FIFO_DEPTH, even if a pop happens the same cycle.
  - The pointer moves only on a grant.
- FIFO:
  - out_* show the head record whenever count > 0.
  - A pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (async assert, any time including mid-frame):
  - All FSMs go to IDLE; filters, slots and FIFO clear.
  - Round-robin pointer = NUM_CH-1, so channel 0 wins first.
  - out_valid = 0, out_data = 0, out_ch = 0, out_error = 0, overflow = 0.

## Timing
- Pin-to-strobe: 2 synchroniser cycles + FILTER_LEN filter cycles + 1 edge-detect cycle.
- After the STOP strobe at cycle T:
  - slot full at T+1;
  - grant and FIFO write at T+2 (if uncontested and FIFO not full);
  - out_valid = 1 at T+3.
- No bypass from an empty FIFO.
- A pop at cycle P updates out_* at P+1.
- out_valid stays at 1 while the FIFO is non-empty, independent of out_ready.
- Sustained throughput: one record per clock across all channels combined.
- The timeout counter reloads on every strobe and is held at 0 in IDLE. The abort fires on the cycle the count reaches TIMEOUT_CYCLES.

## Configuration
- PS2_RX_HUB_TIMEOUT_EN:
  - Defined: timeout counters and timeout records are present, as above.
  - Undefined: no counters; a partial frame waits in its state indefinitely and no timeout record is ever produced. TIMEOUT_CYCLES is ignored.

## Test plan
- NUM_CH=2, out_ready=1. Channel 0 sends 0x1C with parity 0 and stop 1 → one record {err 0, ch 0, data 0x1C}; out_valid rises 3 cycles after the stop strobe.
- Channel 1 sends 0xF0 with parity 0 (wrong; 0xF0 has four ones, so odd parity needs 1) → {1, 1, 0xF0}. A frame with stop 0 → err 1.
- Both channels' STOP strobes land in the same cycle (ch0 0xAA, ch1 0x55) → FIFO order ch0 then ch1. Repeat with the pointer at 0 → ch1 first.
- out_ready=0, channel 0 sends FIFO_DEPTH+2 frames → FIFO full and slot full; the last frame is dropped and overflow[0]=1. Pulse ovf_clr → overflow=0. Then drain → exactly FIFO_DEPTH+1 records in send order.
- PS2_RX_HUB_TIMEOUT_EN defined, channel 0 stops after 4 data bits → after TIMEOUT_CYCLES, record {1, 0, 0x00}, and the next full frame 0x29 decodes cleanly. Undefined → no record; the FSM stays in DATA.
- Assert reset mid-frame with 3 records queued → all outputs 0 immediately. After release, a new frame on channel 0 decodes correctly.

Source files
------------

// File: rtl/ps2_rx_hub.sv
// Multi-channel PS/2 receive hub: per-channel deframers merged round-robin into a shared FWFT FIFO.
// Define PS2_RX_HUB_TIMEOUT_EN to add the mid-frame idle timeout and its timeout records.

module ps2_rx_hub #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_CH-1:0]                               ps2_clk,
    input  logic [NUM_CH-1:0]                               ps2_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [7:0]                                      out_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  out_ch,
    output logic                                            out_error,
    output logic [NUM_CH-1:0]                               overflow,
    input  logic                                            ovf_clr
);

    localparam int unsigned CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned REC_W = 9 + CHW;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FLW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [NUM_CH-1:0] clk_s1, clk_s2, dat_s1, dat_s2;
    logic [NUM_CH-1:0] emit_v;
    logic [REC_W-1:0]  emit_rec [NUM_CH];

    // Two-flop synchronisers; lines idle high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1 <= '1;
            clk_s2 <= '1;
            dat_s1 <= '1;
            dat_s2 <= '1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        logic [FLW-1:0] flt_cnt;
        logic           flt_clk, flt_prev, strobe;
        logic [1:0]     state_q, state_d;
        logic [2:0]     bit_q, bit_d;
        logic [7:0]     shift_q, shift_d;
        logic           par_q, par_d;
        logic           emit_c, emit_err_c;
        logic [7:0]     emit_byte_c;

        // Glitch filter: a level change needs FILTER_LEN consecutive samples
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                flt_cnt  <= '0;
                flt_clk  <= 1'b1;
                flt_prev <= 1'b1;
            end else begin
                flt_prev <= flt_clk;
                if (clk_s2[i] != flt_clk) begin
                    if (flt_cnt == FLW'(FILTER_LEN - 1)) begin
                        flt_clk <= clk_s2[i];
                        flt_cnt <= '0;
                    end else begin
                        flt_cnt <= flt_cnt + FLW'(1);
                    end
                end else begin
                    flt_cnt <= '0;
                end
            end
        end

        assign strobe = flt_prev & ~flt_clk;

`ifdef PS2_RX_HUB_TIMEOUT_EN
        localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
        logic [TW-1:0] to_q, to_d;
`else
        // TIMEOUT_CYCLES has no effect without the timeout feature
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
        end
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                bit_q   <= '0;
                shift_q <= '0;
                par_q   <= 1'b0;
`ifdef PS2_RX_HUB_TIMEOUT_EN
                to_q    <= '0;
`endif
            end else begin
                state_q <= state_d;
                bit_q   <= bit_d;
                shift_q <= shift_d;
                par_q   <= par_d;
`ifdef PS2_RX_HUB_TIMEOUT_EN
                to_q    <= to_d;
`endif
            end
        end

        always_comb begin
            state_d     = state_q;
            bit_d       = bit_q;
            shift_d     = shift_q;
            par_d       = par_q;
            emit_c      = 1'b0;
            emit_err_c  = 1'b0;
            emit_byte_c = shift_q;
            case (state_q)
                ST_IDLE: begin
                    if (strobe && !dat_s2[i]) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end
                end
                ST_DATA: begin
                    if (strobe) begin
                        shift_d = {dat_s2[i], shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (strobe) begin
                        par_d   = dat_s2[i];
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (strobe) begin
                        emit_c     = 1'b1;
                        emit_err_c = ~(^{shift_q, par_q}) | ~dat_s2[i];
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
`ifdef PS2_RX_HUB_TIMEOUT_EN
            to_d = '0;
            if (state_q != ST_IDLE && !strobe) begin
                to_d = to_q + TW'(1);
                if (to_d == TW'(TIMEOUT_CYCLES)) begin
                    to_d        = '0;
                    state_d     = ST_IDLE;
                    emit_c      = 1'b1;
                    emit_err_c  = 1'b1;
                    emit_byte_c = 8'h00;
                end
            end
`endif
        end

        assign emit_v[i]   = emit_c;
        assign emit_rec[i] = {emit_err_c, CHW'(i), emit_byte_c};
    end

    logic [NUM_CH-1:0] slot_full;
    logic [REC_W-1:0]  slot_rec [NUM_CH];
    logic [CHW-1:0]    rr_ptr_q, gnt_idx;
    logic [CHW:0]      cand;
    logic              gnt_any, can_grant;
    logic [NUM_CH-1:0] gnt_vec, ovf_set;
    logic              wr_valid_q;
    logic [REC_W-1:0]  wr_rec_q;
    logic [CNTW-1:0]   count_q, count_d;

    // Round-robin search from last grant + 1; a write already in flight counts toward fullness
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = rr_ptr_q;
        gnt_vec   = '0;
        cand      = '0;
        can_grant = ({1'b0, count_q} + (CNTW+1)'(wr_valid_q)) < (CNTW+1)'(FIFO_DEPTH);
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            cand = (CHW+1)'(rr_ptr_q) + (CHW+1)'(k);
            if (cand >= (CHW+1)'(NUM_CH)) cand = cand - (CHW+1)'(NUM_CH);
            if (!gnt_any && can_grant && slot_full[cand[CHW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[CHW-1:0];
            end
        end
        if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
    end

    assign ovf_set = emit_v & slot_full & ~gnt_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_full  <= '0;
            overflow   <= '0;
            rr_ptr_q   <= CHW'(NUM_CH - 1);
            wr_valid_q <= 1'b0;
            wr_rec_q   <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) slot_rec[c] <= '0;
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (emit_v[c] && (!slot_full[c] || gnt_vec[c])) begin
                    slot_full[c] <= 1'b1;
                    slot_rec[c]  <= emit_rec[c];
                end else if (gnt_vec[c]) begin
                    slot_full[c] <= 1'b0;
                end
            end
            overflow   <= ovf_clr ? '0 : (overflow | ovf_set);
            wr_valid_q <= gnt_any;
            if (gnt_any) begin
                wr_rec_q <= slot_rec[gnt_idx];
                rr_ptr_q <= gnt_idx;
            end
        end
    end

    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic             pop_c;
    logic [REC_W-1:0] head;

    assign pop_c   = out_valid & out_ready;
    assign count_d = count_q + CNTW'(wr_valid_q) - CNTW'(pop_c);

    // Shared FIFO; storage clears on reset so the head reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            for (int d = 0; d < int'(FIFO_DEPTH); d++) mem[d] <= '0;
        end else begin
            if (wr_valid_q) begin
                mem[wr_ptr_q] <= wr_rec_q;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_d;
            out_valid <= (count_d != '0);
        end
    end

    assign head      = mem[rd_ptr_q];
    assign out_data  = head[7:0];
    assign out_ch    = head[8 +: CHW];
    assign out_error = head[REC_W-1];

endmodule

// File: tb/tb_ps2_rx_hub.sv
// Scoreboard bench for ps2_rx_hub: PS/2 frame driver, reference record queue and popping monitor.
// Covers the PS2_RX_HUB_TIMEOUT_EN build and the default build.

module tb_ps2_rx_hub;
    localparam int unsigned NUM_CH     = 2;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned TIMEOUT    = 1000;
    localparam int unsigned CHW        = 1;
    localparam int unsigned HP         = 20;

    typedef struct packed {
        logic           err;
        logic [CHW-1:0] ch;
        logic [7:0]     data;
    } rec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NUM_CH-1:0] ps2_clk = '1;
    logic [NUM_CH-1:0] ps2_data = '1;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [7:0]        out_data;
    logic [CHW-1:0]    out_ch;
    logic              out_error;
    logic [NUM_CH-1:0] overflow;
    logic              ovf_clr = 1'b0;

    ps2_rx_hub #(
        .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH),
        .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_error(out_error), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned stop_cyc = 0;
    int unsigned rise_cyc = 0;
    logic        v_prev = 1'b0;
    bit          hold = 1'b1;
    int          last_ch = NUM_CH - 1;
    rec_t        exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: choose ready for the coming edge, then score whatever that edge pops
    always @(negedge clk) begin
        rec_t e;
        out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (out_valid && !v_prev) rise_cyc = cyc;
        v_prev = out_valid;
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got ch=%0d data=0x%0h err=%0d with nothing expected",
                         out_ch, out_data, out_error);
            end else begin
                e = exp_q.pop_front();
                check("rec_data", out_data, e.data);
                check("rec_ch", out_ch, e.ch);
                check("rec_err", out_error, e.err);
            end
        end
    end

    function automatic logic odd_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    task automatic expect_rec(input int ch, input logic [7:0] b, input logic par, input logic stp);
        rec_t r;
        r.err  = ((^b) ^ par) != 1'b1 || stp != 1'b1;
        r.ch   = CHW'(ch);
        r.data = b;
        exp_q.push_back(r);
        last_ch = ch;
    endtask

    task automatic ps2_bit(input int ch, input logic b, input bit mark);
        ps2_data[ch] = b;
        repeat (HP/2) @(negedge clk);
        ps2_clk[ch] = 1'b0;
        if (mark) stop_cyc = cyc;
        repeat (HP) @(negedge clk);
        ps2_clk[ch] = 1'b1;
        repeat (HP/2) @(negedge clk);
    endtask

    task automatic send_frame(input int ch, input logic [7:0] b, input logic par,
                              input logic stp, input int nbits);
        ps2_bit(ch, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(ch, b[i], 1'b0);
        if (nbits == 8) begin
            ps2_bit(ch, par, 1'b0);
            ps2_bit(ch, stp, 1'b1);
        end
        ps2_data[ch] = 1'b1;
    endtask

    task automatic frame(input int ch, input logic [7:0] b, input logic par, input logic stp);
        expect_rec(ch, b, par, stp);
        send_frame(ch, b, par, stp, 8);
    endtask

    // Both channels finish in the same cycle; the model orders them by the last grant
    task automatic pair(input logic [7:0] b0, input logic p0, input logic [7:0] b1, input logic p1);
        if (((last_ch + 1) % NUM_CH) == 0) begin
            expect_rec(0, b0, p0, 1'b1);
            expect_rec(1, b1, p1, 1'b1);
        end else begin
            expect_rec(1, b1, p1, 1'b1);
            expect_rec(0, b0, p0, 1'b1);
        end
        fork
            send_frame(0, b0, p0, 1'b1, 8);
            send_frame(1, b1, p1, 1'b1, 8);
        join
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(negedge clk);
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_ch"}, out_ch, 0);
        check({tag, "_error"}, out_error, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d records outstanding", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b0, b1;
        logic       p0, p1, s0;
        int         mode;

        repeat (5) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b1;
        hold  = 1'b0;
        repeat (5) @(negedge clk);

        // Clean frame and output latency from the stop-bit pin edge
        frame(0, 8'h1C, 1'b0, 1'b1);
        wait_drain("drain_basic", 500);
        check("stop_to_valid_latency", rise_cyc - stop_cyc, FILTER_LEN + 5);

        frame(1, 8'hF0, 1'b0, 1'b1);
        frame(0, 8'h3A, odd_par(8'h3A), 1'b0);
        frame(1, 8'h12, odd_par(8'h12), 1'b1);
        wait_drain("drain_errors", 500);

        // Simultaneous frames: after ch1 wins, ch0 first; after ch0 wins, ch1 first
        frame(1, 8'h07, odd_par(8'h07), 1'b1);
        pair(8'hAA, odd_par(8'hAA), 8'h55, odd_par(8'h55));
        wait_drain("drain_pair_a", 500);
        frame(0, 8'h61, odd_par(8'h61), 1'b1);
        wait_drain("drain_single", 500);
        pair(8'hAA, odd_par(8'hAA), 8'h55, odd_par(8'h55));
        wait_drain("drain_pair_b", 500);

        // Overflow: FIFO plus one slot absorb DEPTH+1 frames, the next is dropped
        hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < int'(FIFO_DEPTH) + 2; i++) begin
            b0 = 8'(i * 17 + 3);
            if (i < int'(FIFO_DEPTH) + 1) expect_rec(0, b0, odd_par(b0), 1'b1);
            send_frame(0, b0, odd_par(b0), 1'b1, 8);
        end
        repeat (10) @(negedge clk);
        check("full_valid", out_valid, 1);
        check("overflow_set", overflow, 2'b01);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        @(negedge clk);
        check("overflow_cleared", overflow, 0);
        hold = 1'b0;
        wait_drain("drain_overflow", 1000);

        // Randomised singles and simultaneous pairs with random backpressure
        for (int it = 0; it < 20; it++) begin
            mode = $urandom_range(0, 2);
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            p0 = odd_par(b0) ^ ($urandom_range(0, 3) == 0);
            p1 = odd_par(b1) ^ ($urandom_range(0, 3) == 0);
            s0 = ($urandom_range(0, 5) != 0);
            if (mode == 2) pair(b0, p0, b1, p1);
            else frame(mode, b0, p0, s0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_drain("drain_random", 2000);

`ifdef PS2_RX_HUB_TIMEOUT_EN
        // Abandoned frame produces a timeout record, then the channel decodes normally
        expect_rec(0, 8'h00, 1'b0, 1'b0);
        send_frame(0, 8'h0F, 1'b0, 1'b1, 4);
        wait_drain("drain_timeout", int'(TIMEOUT) + 500);
        frame(0, 8'h29, odd_par(8'h29), 1'b1);
        wait_drain("drain_after_timeout", 1000);
`else
        // Without the timeout an abandoned frame stays pending and emits nothing
        send_frame(0, 8'h0F, 1'b0, 1'b1, 4);
        repeat (2 * TIMEOUT) @(negedge clk);
        check("no_timeout_record", out_valid, 0);
`endif

        // Reset mid-frame with records queued
        hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) send_frame(1, 8'(8'h40 + i), odd_par(8'(8'h40 + i)), 1'b1, 8);
        repeat (20) @(negedge clk);
        check("queued_valid", out_valid, 1);
        send_frame(1, 8'hFF, 1'b0, 1'b1, 4);
        #3 reset = 1'b0;
        #1 check_zero_outputs("midreset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset   = 1'b1;
        last_ch = NUM_CH - 1;
        hold    = 1'b0;
        repeat (3) @(negedge clk);
        frame(0, 8'h5A, odd_par(8'h5A), 1'b1);
        frame(1, 8'hC3, odd_par(8'hC3), 1'b1);
        wait_drain("drain_after_reset", 1000);

        check("final_overflow", overflow, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
